// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// flush squashing, external hold and a saturating bubble counter.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instr_ID,
   input  logic [31:0] pc_ID,
   input  logic [31:0] imm_ID,
   input  logic [31:0] rs1_rdata_ID,
   input  logic [31:0] rs2_rdata_ID,
   input  logic [4:0]  rs1_raddr_ID,
   input  logic [4:0]  rs2_raddr_ID,
   input  logic [4:0]  rd_waddr_ID,
   input  logic [1:0]  rs1_ID_fwd,
   input  logic [1:0]  rs2_ID_fwd,
   input  logic [31:0] alu_result_EX,
   input  logic [31:0] alu_result_M,
   input  logic [31:0] mem_rdata_M,
   input  logic        hold,
   input  logic        flush,
   output logic [31:0] instr_EX,
   output logic [31:0] pc_EX,
   output logic [31:0] imm_EX,
   output logic [31:0] rs1_rdata_EX,
   output logic [31:0] rs2_rdata_EX,
   output logic [4:0]  rs1_raddr_EX,
   output logic [4:0]  rs2_raddr_EX,
   output logic [4:0]  rd_waddr_EX,
   output logic        stall_ID,
   output logic [15:0] bubble_cnt,
   output logic        lu_stall_o
);

   localparam logic [31:0] NOP           = 32'h0000_0013;
   localparam logic [6:0]  R_TYPE        = 7'b0110011;
   localparam logic [6:0]  I_TYPE_LOAD   = 7'b0000011;
   localparam logic [6:0]  I_TYPE_OP_IMM = 7'b0010011;
   localparam logic [6:0]  S_TYPE        = 7'b0100011;
   localparam logic [6:0]  B_TYPE        = 7'b1100011;

   typedef enum logic {RUN = 1'b0, LU_STALL = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] instr_q, instr_d, pc_q, pc_d, imm_q, imm_d;
   logic [31:0] rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
   logic [4:0]  rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_q, rd_d;
   logic [15:0] cnt_q, cnt_d;

   logic [6:0]  op_id;
   logic        uses_rs1, uses_rs2, lu_hazard;
   logic [31:0] rs1_mux, rs2_mux;

   assign op_id    = instr_ID[6:0];
   assign uses_rs1 = (op_id == R_TYPE) || (op_id == I_TYPE_LOAD) || (op_id == I_TYPE_OP_IMM) ||
                     (op_id == S_TYPE) || (op_id == B_TYPE);
   assign uses_rs2 = (op_id == R_TYPE) || (op_id == S_TYPE) || (op_id == B_TYPE);

   // A load in EX whose destination is consumed by the ID instruction.
   assign lu_hazard = (instr_q[6:0] == I_TYPE_LOAD) && (rd_q != 5'd0) &&
                      ((uses_rs1 && (rs1_raddr_ID == rd_q)) || (uses_rs2 && (rs2_raddr_ID == rd_q)));

   always_comb begin
      case (rs1_ID_fwd)
         2'd0:    rs1_mux = rs1_rdata_ID;
         2'd1:    rs1_mux = alu_result_EX;
         2'd2:    rs1_mux = alu_result_M;
         default: rs1_mux = mem_rdata_M;
      endcase
      case (rs2_ID_fwd)
         2'd0:    rs2_mux = rs2_rdata_ID;
         2'd1:    rs2_mux = alu_result_EX;
         2'd2:    rs2_mux = alu_result_M;
         default: rs2_mux = mem_rdata_M;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      instr_d    = instr_q;
      pc_d       = pc_q;
      imm_d      = imm_q;
      rs1_data_d = rs1_data_q;
      rs2_data_d = rs2_data_q;
      rs1_addr_d = rs1_addr_q;
      rs2_addr_d = rs2_addr_q;
      rd_d       = rd_q;
      cnt_d      = cnt_q;
      if (!hold) begin
         if (flush || ((state_q == RUN) && lu_hazard)) begin
            // Bubble: keep the PC of the squashed/held instruction for traceability.
            state_d    = flush ? RUN : LU_STALL;
            instr_d    = NOP;
            pc_d       = pc_ID;
            imm_d      = 32'd0;
            rs1_data_d = 32'd0;
            rs2_data_d = 32'd0;
            rs1_addr_d = 5'd0;
            rs2_addr_d = 5'd0;
            rd_d       = 5'd0;
            cnt_d      = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
         end else begin
            state_d    = RUN;
            instr_d    = instr_ID;
            pc_d       = pc_ID;
            imm_d      = imm_ID;
            rs1_data_d = rs1_mux;
            rs2_data_d = rs2_mux;
            rs1_addr_d = rs1_raddr_ID;
            rs2_addr_d = rs2_raddr_ID;
            rd_d       = rd_waddr_ID;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         instr_q    <= NOP;
         pc_q       <= 32'd0;
         imm_q      <= 32'd0;
         rs1_data_q <= 32'd0;
         rs2_data_q <= 32'd0;
         rs1_addr_q <= 5'd0;
         rs2_addr_q <= 5'd0;
         rd_q       <= 5'd0;
         cnt_q      <= 16'd0;
      end else begin
         state_q    <= state_d;
         instr_q    <= instr_d;
         pc_q       <= pc_d;
         imm_q      <= imm_d;
         rs1_data_q <= rs1_data_d;
         rs2_data_q <= rs2_data_d;
         rs1_addr_q <= rs1_addr_d;
         rs2_addr_q <= rs2_addr_d;
         rd_q       <= rd_d;
         cnt_q      <= cnt_d;
      end
   end

   assign stall_ID     = rst_n && (hold || ((state_q == RUN) && !flush && lu_hazard));
   assign instr_EX     = instr_q;
   assign pc_EX        = pc_q;
   assign imm_EX       = imm_q;
   assign rs1_rdata_EX = rs1_data_q;
   assign rs2_rdata_EX = rs2_data_q;
   assign rs1_raddr_EX = rs1_addr_q;
   assign rs2_raddr_EX = rs2_addr_q;
   assign rd_waddr_EX  = rd_q;
   assign bubble_cnt   = cnt_q;
   assign lu_stall_o   = (state_q == LU_STALL);

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed and randomized bench for id_ex_stage against a transaction-level
// model of the ID/EX register (hazard rule, bubble/flush/hold, counter).
module tb_id_ex_stage;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ADD_X3 = 32'h0020_81B3;  // add x3,x1,x2
   localparam logic [31:0] LW_X5  = 32'h0000_A283;  // lw  x5,0(x1)
   localparam logic [31:0] ADD_X6 = 32'h0072_8333;  // add x6,x5,x7
   localparam logic [31:0] LW_X0  = 32'h0000_A003;  // lw  x0,0(x1)
   localparam logic [31:0] ADD_X0 = 32'h0070_0333;  // add x6,x0,x7

   logic        clk, rst_n;
   logic [31:0] instr_ID, pc_ID, imm_ID, rs1_rdata_ID, rs2_rdata_ID;
   logic [4:0]  rs1_raddr_ID, rs2_raddr_ID, rd_waddr_ID;
   logic [1:0]  rs1_ID_fwd, rs2_ID_fwd;
   logic [31:0] alu_result_EX, alu_result_M, mem_rdata_M;
   logic        hold, flush;
   logic [31:0] instr_EX, pc_EX, imm_EX, rs1_rdata_EX, rs2_rdata_EX;
   logic [4:0]  rs1_raddr_EX, rs2_raddr_EX, rd_waddr_EX;
   logic        stall_ID, lu_stall_o;
   logic [15:0] bubble_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Model of the EX payload and of "the previous edge inserted a load-use bubble".
   logic [31:0] m_instr, m_pc, m_imm, m_rs1d, m_rs2d;
   logic [4:0]  m_rs1a, m_rs2a, m_rd;
   bit          m_in_stall;
   int          m_cnt;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .instr_ID(instr_ID), .pc_ID(pc_ID), .imm_ID(imm_ID),
      .rs1_rdata_ID(rs1_rdata_ID), .rs2_rdata_ID(rs2_rdata_ID),
      .rs1_raddr_ID(rs1_raddr_ID), .rs2_raddr_ID(rs2_raddr_ID), .rd_waddr_ID(rd_waddr_ID),
      .rs1_ID_fwd(rs1_ID_fwd), .rs2_ID_fwd(rs2_ID_fwd),
      .alu_result_EX(alu_result_EX), .alu_result_M(alu_result_M), .mem_rdata_M(mem_rdata_M),
      .hold(hold), .flush(flush),
      .instr_EX(instr_EX), .pc_EX(pc_EX), .imm_EX(imm_EX),
      .rs1_rdata_EX(rs1_rdata_EX), .rs2_rdata_EX(rs2_rdata_EX),
      .rs1_raddr_EX(rs1_raddr_EX), .rs2_raddr_EX(rs2_raddr_EX), .rd_waddr_EX(rd_waddr_EX),
      .stall_ID(stall_ID), .bubble_cnt(bubble_cnt), .lu_stall_o(lu_stall_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit reads_rs1(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit reads_rs2(input logic [6:0] op);
      return op inside {7'b0110011, 7'b0100011, 7'b1100011};
   endfunction

   function automatic bit model_hazard();
      logic [6:0] ex_op, id_op;
      ex_op = m_instr[6:0];
      id_op = instr_ID[6:0];
      if (ex_op != 7'b0000011 || m_rd == 5'd0) return 1'b0;
      return (reads_rs1(id_op) && rs1_raddr_ID == m_rd) || (reads_rs2(id_op) && rs2_raddr_ID == m_rd);
   endfunction

   function automatic logic [31:0] operand(input logic [1:0] sel, input logic [31:0] rf);
      logic [31:0] src [4];
      src[0] = rf; src[1] = alu_result_EX; src[2] = alu_result_M; src[3] = mem_rdata_M;
      return src[sel];
   endfunction

   task automatic model_reset();
      m_instr = NOP; m_pc = 0; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
      m_rs1a = 0; m_rs2a = 0; m_rd = 0; m_in_stall = 0; m_cnt = 0;
   endtask

   task automatic model_edge();
      if (hold) return;
      if (flush || (!m_in_stall && model_hazard())) begin
         m_in_stall = !flush;
         m_instr = NOP; m_pc = pc_ID; m_imm = 0; m_rs1d = 0; m_rs2d = 0;
         m_rs1a = 0; m_rs2a = 0; m_rd = 0;
         if (m_cnt < 65535) m_cnt++;
      end else begin
         m_in_stall = 0;
         m_instr = instr_ID; m_pc = pc_ID; m_imm = imm_ID;
         m_rs1d = operand(rs1_ID_fwd, rs1_rdata_ID);
         m_rs2d = operand(rs2_ID_fwd, rs2_rdata_ID);
         m_rs1a = rs1_raddr_ID; m_rs2a = rs2_raddr_ID; m_rd = rd_waddr_ID;
      end
   endtask

   task automatic check_outputs();
      chk("instr_EX", instr_EX, m_instr);
      chk("pc_EX", pc_EX, m_pc);
      chk("imm_EX", imm_EX, m_imm);
      chk("rs1_rdata_EX", rs1_rdata_EX, m_rs1d);
      chk("rs2_rdata_EX", rs2_rdata_EX, m_rs2d);
      chk("rs1_raddr_EX", 32'(rs1_raddr_EX), 32'(m_rs1a));
      chk("rs2_raddr_EX", 32'(rs2_raddr_EX), 32'(m_rs2a));
      chk("rd_waddr_EX", 32'(rd_waddr_EX), 32'(m_rd));
      chk("bubble_cnt", 32'(bubble_cnt), 32'(m_cnt));
      chk("lu_stall", 32'(lu_stall_o), 32'(m_in_stall));
   endtask

   // Called at a falling edge with ID inputs settled; returns at the next falling edge.
   task automatic cycle();
      #1;
      chk("stall_ID", 32'(stall_ID), 32'(hold || (!m_in_stall && !flush && model_hazard())));
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
      @(negedge clk);
   endtask

   task automatic set_id(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
      instr_ID = ins; pc_ID = pc; imm_ID = {20'd0, ins[31:20]};
      rs1_raddr_ID = rs1; rs2_raddr_ID = rs2; rd_waddr_ID = rd;
      rs1_rdata_ID = 32'h1000_0000 | 32'(rs1); rs2_rdata_ID = 32'h2000_0000 | 32'(rs2);
   endtask

   task automatic randomize_inputs();
      logic [6:0]  ops [6];
      logic [31:0] r;
      ops[0] = 7'b0110011; ops[1] = 7'b0000011; ops[2] = 7'b0010011;
      ops[3] = 7'b0100011; ops[4] = 7'b1100011; ops[5] = 7'b0110111;
      r = $urandom();
      instr_ID      = {r[31:7], ops[$urandom_range(0, 5)]};
      pc_ID         = $urandom();
      imm_ID        = $urandom();
      rs1_rdata_ID  = $urandom();
      rs2_rdata_ID  = $urandom();
      rs1_raddr_ID  = 5'($urandom_range(0, 3));
      rs2_raddr_ID  = 5'($urandom_range(0, 3));
      rd_waddr_ID   = 5'($urandom_range(0, 3));
      rs1_ID_fwd    = 2'($urandom_range(0, 3));
      rs2_ID_fwd    = 2'($urandom_range(0, 3));
      alu_result_EX = $urandom();
      alu_result_M  = $urandom();
      mem_rdata_M   = $urandom();
      hold          = ($urandom_range(0, 7) == 0);
      flush         = ($urandom_range(0, 7) == 0);
   endtask

   initial begin
      rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
      rs1_ID_fwd = 2'd0; rs2_ID_fwd = 2'd0;
      alu_result_EX = 32'hA1A1_A1A1; alu_result_M = 32'hB2B2_B2B2; mem_rdata_M = 32'hC3C3_C3C3;
      set_id(ADD_X3, 32'h100, 5'd1, 5'd2, 5'd3);
      model_reset();
      @(negedge clk);
      check_outputs();
      chk("reset_instr_nop", instr_EX, 32'h0000_0013);
      chk("reset_stall", 32'(stall_ID), 32'd0);
      rst_n = 1'b1;

      // Plain advance with register-file operands
      set_id(ADD_X3, 32'h100, 5'd1, 5'd2, 5'd3);
      cycle();
      chk("add_instr", instr_EX, ADD_X3);
      chk("add_rs1", rs1_rdata_EX, 32'h1000_0001);
      chk("add_rs2", rs2_rdata_EX, 32'h2000_0002);

      // Load-use: one bubble, then operand taken from M load data
      set_id(LW_X5, 32'h104, 5'd1, 5'd0, 5'd5);
      cycle();
      set_id(ADD_X6, 32'h108, 5'd5, 5'd7, 5'd6);
      cycle();
      chk("lu_bubble_instr", instr_EX, NOP);
      chk("lu_bubble_cnt", 32'(bubble_cnt), 32'd1);
      rs1_ID_fwd = 2'd3; mem_rdata_M = 32'hDEAD_BEEF;
      cycle();
      chk("lu_fwd_rs1", rs1_rdata_EX, 32'hDEAD_BEEF);
      chk("lu_released", instr_EX, ADD_X6);
      rs1_ID_fwd = 2'd0;

      // Load to x0 never stalls
      set_id(LW_X0, 32'h10C, 5'd1, 5'd0, 5'd0);
      cycle();
      set_id(ADD_X0, 32'h110, 5'd0, 5'd7, 5'd6);
      cycle();
      chk("x0_no_bubble", 32'(bubble_cnt), 32'd1);

      // Flush wins over a coincident load-use hazard
      set_id(LW_X5, 32'h114, 5'd1, 5'd0, 5'd5);
      cycle();
      set_id(ADD_X6, 32'h118, 5'd5, 5'd7, 5'd6);
      flush = 1'b1;
      cycle();
      flush = 1'b0;
      chk("flush_cnt", 32'(bubble_cnt), 32'd2);
      chk("flush_state", 32'(lu_stall_o), 32'd0);

      // Hold for three cycles inside a load-use stall
      set_id(LW_X5, 32'h11C, 5'd1, 5'd0, 5'd5);
      cycle();
      set_id(ADD_X6, 32'h120, 5'd5, 5'd7, 5'd6);
      cycle();
      hold = 1'b1;
      repeat (3) cycle();
      chk("hold_state", 32'(lu_stall_o), 32'd1);
      hold = 1'b0; rs1_ID_fwd = 2'd3; mem_rdata_M = 32'h0BAD_F00D;
      cycle();
      chk("hold_release", rs1_rdata_EX, 32'h0BAD_F00D);
      rs1_ID_fwd = 2'd0;

      // Asynchronous reset in the middle of a load-use stall
      set_id(LW_X5, 32'h124, 5'd1, 5'd0, 5'd5);
      cycle();
      set_id(ADD_X6, 32'h128, 5'd5, 5'd7, 5'd6);
      cycle();
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      chk("async_rst_stall", 32'(stall_ID), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cycle();
      chk("post_rst_latch", instr_EX, ADD_X6);

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         randomize_inputs();
         cycle();
      end

      // Drive the bubble counter into saturation with back-to-back flushes
      hold = 1'b0; flush = 1'b1;
      while (m_cnt < 65535) begin
         @(posedge clk);
         model_edge();
      end
      #1;
      check_outputs();
      @(negedge clk);
      repeat (3) cycle();
      chk("cnt_saturated", 32'(bubble_cnt), 32'h0000_FFFF);
      flush = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 clk  in  1  rising-edge clock for all state.
REQ-002 rst_n  in  1  asynchronous active-low reset.
REQ-003 instr_ID, pc_ID  in  32 each  decoded instruction and its PC in ID.
REQ-004 imm_ID  in  32  sign-extended immediate from decoder.
REQ-005 rs1_rdata_ID, rs2_rdata_ID  in  32 each  register-file read data.
REQ-006 rs1_raddr_ID, rs2_raddr_ID, rd_waddr_ID  in  5 each  register addresses in ID.
REQ-007 rs1_ID_fwd, rs2_ID_fwd  in  2 each  forward selects; 0 regfile, 1 EX ALU result, 2 M ALU result, 3 M load data.
REQ-008 alu_result_EX, alu_result_M, mem_rdata_M  in  32 each  forwarding sources.
REQ-009 hold  in  1  external freeze (memory wait); all state held.
REQ-010 flush  in  1  branch/jump taken; squash the ID instruction.
REQ-011 instr_EX, pc_EX, imm_EX, rs1_rdata_EX, rs2_rdata_EX  out  32 each  registered EX-stage payload.
REQ-012 rs1_raddr_EX, rs2_raddr_EX, rd_waddr_EX  out  5 each  registered EX-stage addresses.
REQ-013 stall_ID  out  1  combinational; IF/ID registers hold when 1.
REQ-014 bubble_cnt  out  16  count of NOPs inserted into EX.

Function
REQ-015 Operand mux per rsN_ID_fwd: 0 rsN_rdata_ID, 1 alu_result_EX, 2 alu_result_M, 3 mem_rdata_M; applied to rs1 and rs2 independently.
REQ-016 NOP = 32'h00000013 (addi x0,x0,0); NOP insertion loads instr_EX=NOP, rd/rs1/rs2 addr=0, data/imm=0, pc_EX=pc_ID.
REQ-017 lu_hazard = opcode(instr_EX)==I_TYPE_LOAD, rd_waddr_EX!=0, and (rs1_raddr_ID==rd_waddr_EX with ID opcode in {R_TYPE, I_TYPE_LOAD, I_TYPE_OP_IMM, S_TYPE, B_TYPE}) or (rs2_raddr_ID==rd_waddr_EX with ID opcode in {R_TYPE, S_TYPE, B_TYPE}).
REQ-018 Opcode constants from Def.v; opcode = instr[6:0].
REQ-019 FSM states RUN, LU_STALL; 1-bit state register.
REQ-020 Per-edge priority: hold > flush > lu_hazard > normal advance.
REQ-021 hold=1: every EX register, state and bubble_cnt unchanged; stall_ID=1.
REQ-022 RUN, flush=1: insert NOP into EX, stay RUN, stall_ID=0.
REQ-023 RUN, lu_hazard=1, flush=0: insert NOP into EX, go LU_STALL, stall_ID=1.
REQ-024 RUN, otherwise: latch ID payload with muxed operands into EX, stay RUN, stall_ID=0.
REQ-025 LU_STALL (no hold): lu_hazard not evaluated; latch ID payload (operand now from M via fwd=3) or NOP if flush; return RUN; stall_ID=0.
REQ-026 Load-use bubble is exactly one cycle; back-to-back dependent loads each cost one bubble.
REQ-027 bubble_cnt increments by 1 on each NOP insertion, saturates at 16'hFFFF.
REQ-028 Latency ID->EX: one clock when not stalled or held.

Reset
REQ-029 rst_n=0 asynchronously: instr_EX=NOP, all other EX outputs 0, state=RUN, bubble_cnt=0.
REQ-030 stall_ID=0 during reset (state RUN, instr_EX NOP => no hazard).
REQ-031 Reset asserted mid-LU_STALL discards pending instruction; first edge after release latches current ID.

Verification
REQ-032 add x3,x1,x2 in ID, fwd=0, no hazard -> next edge instr_EX=add, rs1/rs2_rdata_EX = regfile values, stall_ID=0.
REQ-033 lw x5 in EX, add x6,x5,x7 in ID -> stall_ID=1 one cycle, instr_EX=NOP, bubble_cnt 0->1; next edge with rs1_ID_fwd=3, mem_rdata_M=32'hDEADBEEF -> rs1_rdata_EX=32'hDEADBEEF.
REQ-034 lw x0 in EX, add using x0 in ID -> no stall, bubble_cnt unchanged.
REQ-035 flush=1 and lu_hazard=1 same cycle -> NOP inserted, state RUN, stall_ID=0, bubble_cnt +1.
REQ-036 hold=1 for 3 cycles during LU_STALL -> outputs and state frozen, then release completes stall in one edge.
REQ-037 rst_n low mid-pipeline -> outputs immediately reset values without clock edge; force bubble_cnt to 16'hFFFF path -> stays 16'hFFFF on further NOPs.
